// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: MDU FSM encoding and
// register-match helper.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MDU_BUSY = 1'b1
    } mdu_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Register 0 is hardwired, so a dependency through it is never a hazard.
    function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
        return (a != REG_ZERO) && (a == b);
    endfunction

    function automatic int mdu_cnt_width(input int div_cycles);
        return (div_cycles > 1) ? $clog2(div_cycles) : 1;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_mdu_busy_timer.sv
// MDU occupancy tracker: loads the op latency on issue, counts down, and flags
// the final busy cycle.
module mdu_busy_timer
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic is_div,
    output logic busy,
    output logic done
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    mdu_state_e       state_r;
    logic [CNT_W-1:0] cnt_r;

    // FSM and countdown; a start on the final busy cycle chains straight into the next op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
            cnt_r   <= CNT_ZERO;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (start) begin
                        state_r <= ST_MDU_BUSY;
                        cnt_r   <= is_div ? DIV_LOAD : MUL_LOAD;
                    end else begin
                        state_r <= ST_RUN;
                        cnt_r   <= CNT_ZERO;
                    end
                end
                ST_MDU_BUSY: begin
                    if (cnt_r == CNT_ZERO) begin
                        if (start) begin
                            state_r <= ST_MDU_BUSY;
                            cnt_r   <= is_div ? DIV_LOAD : MUL_LOAD;
                        end else begin
                            state_r <= ST_RUN;
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    state_r <= ST_RUN;
                    cnt_r   <= CNT_ZERO;
                end
            endcase
        end
    end

    assign busy = (state_r == ST_MDU_BUSY);
    assign done = (state_r == ST_MDU_BUSY) && (cnt_r == CNT_ZERO);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage MIPS pipeline with MDU occupancy
// tracking and a saturating stall-cycle counter.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  RsD,
    input  logic [4:0]  RtD,
    input  logic        BranchD,
    input  logic        MduUseD,
    input  logic [4:0]  RtE,
    input  logic [4:0]  WriteRegE,
    input  logic        RegWriteE,
    input  logic        MemtoRegE,
    input  logic        MduStartE,
    input  logic        MduIsDivE,
    input  logic        MispredictE,
    input  logic [4:0]  WriteRegM,
    input  logic        MemtoRegM,
    input  logic        ImemReadyF,
    output logic        StallF,
    output logic        StallD,
    output logic        FlushD,
    output logic        FlushE,
    output logic        MduBusy,
    output logic        MduDone,
    output logic [31:0] StallCnt
);

    localparam int CNT_W = mdu_cnt_width(DIV_CYCLES);

    logic        lwstall_s;
    logic        brstall_s;
    logic        mdustall_s;
    logic        dstall_s;
    logic        mdu_busy_s;
    logic        mdu_done_s;
    logic [31:0] stall_cnt_r;

    mdu_busy_timer #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) u_mdu_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (MduStartE),
        .is_div (MduIsDivE),
        .busy   (mdu_busy_s),
        .done   (mdu_done_s)
    );

    assign lwstall_s  = MemtoRegE & (reg_match(RtE, RsD) | reg_match(RtE, RtD));
    assign brstall_s  = BranchD &
                        ((RegWriteE & (reg_match(WriteRegE, RsD) | reg_match(WriteRegE, RtD))) |
                         (MemtoRegM & (reg_match(WriteRegM, RsD) | reg_match(WriteRegM, RtD))));
    // The MDU result is forwardable on its done cycle, so no stall is needed then.
    assign mdustall_s = MduUseD & mdu_busy_s & ~mdu_done_s;
    assign dstall_s   = lwstall_s | brstall_s | mdustall_s;

    // Priority mux: redirect beats data hazards, which beat a fetch wait.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        if (!rst_n) begin
            StallF = 1'b0;
            StallD = 1'b0;
            FlushD = 1'b0;
            FlushE = 1'b0;
        end else if (MispredictE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (dstall_s) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end else if (!ImemReadyF) begin
            StallF = 1'b1;
            FlushD = 1'b1;
        end else begin
            StallF = 1'b0;
            StallD = 1'b0;
            FlushD = 1'b0;
            FlushE = 1'b0;
        end
    end

    // Saturating count of decode-stall cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= 32'd0;
        end else if (StallD && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end
    end

    assign MduBusy  = mdu_busy_s;
    assign MduDone  = mdu_done_s;
    assign StallCnt = stall_cnt_r;

endmodule
